// File: rtl/unidade_busca_pkg.sv
// Shared types and constants for the instruction fetch / PC unit of the
// 3-bit-opcode processor.
package busca_pkg;

  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2,
    PARADO  = 2'd3
  } estado_t;

  localparam logic [2:0] OP_TIPO_R = 3'b000;
  localparam logic [2:0] OP_LW     = 3'b001;
  localparam logic [2:0] OP_SW     = 3'b010;
  localparam logic [2:0] OP_BEQZ   = 3'b011;
  localparam logic [2:0] OP_ADDI   = 3'b100;
  localparam logic [2:0] OP_J      = 3'b101;
  localparam logic [2:0] OP_SUB    = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  // Opcode occupies the top OPC_LARG bits of the instruction; the
  // jump target / branch offset occupies the low LARG_PC bits.
  localparam int unsigned OPC_LARG  = 3;
  localparam int unsigned CONT_LARG = 32;

endpackage

// File: rtl/unidade_busca_prox_pc.sv
// Combinational next-PC selection: sequential, taken branch or jump.
// All arithmetic wraps modulo 2^LARG_PC.
module prox_pc #(
  parameter int unsigned LARG_PC = 8
) (
  input  logic [LARG_PC-1:0] pc,
  input  logic [LARG_PC-1:0] campo,
  input  logic               ji,
  input  logic               desvio,
  output logic [LARG_PC-1:0] pc_prox
);

  always_comb begin
    pc_prox = pc + LARG_PC'(1);
    if (ji) begin
      pc_prox = campo;
    end else if (desvio) begin
      // Two's-complement offset: plain modular add gives the signed result.
      pc_prox = pc + LARG_PC'(1) + campo;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch and PC unit. Optional retired-instruction counter
// enabled with macro BUSCA_CONT_INSTR_EN.
module unidade_busca
  import busca_pkg::*;
#(
  parameter int unsigned        LARG_PC    = 8,
  parameter int unsigned        LARG_INSTR = 16,
  parameter logic [LARG_PC-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [LARG_PC-1:0]    mem_addr,
  input  logic                  mem_ack,
  input  logic [LARG_INSTR-1:0] mem_dado,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [LARG_INSTR-1:0] Instrucao,
  output logic [OPC_LARG-1:0]   Opcode,
  output logic [LARG_PC-1:0]    PC,
  input  logic                  Beqz,
  input  logic                  Ji,
  input  logic                  EscPC,
  input  logic                  Zero,
  output logic                  parado
`ifdef BUSCA_CONT_INSTR_EN
  ,
  output logic [CONT_LARG-1:0]  cont_instr
`endif
);

  estado_t               estado_q, estado_d;
  logic [LARG_PC-1:0]    pc_q, pc_d, pc_prox;
  logic [LARG_INSTR-1:0] instr_q, instr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  valid_q, valid_d;
  logic                  parado_q, parado_d;

  prox_pc #(
    .LARG_PC (LARG_PC)
  ) u_prox_pc (
    .pc      (pc_q),
    .campo   (instr_q[LARG_PC-1:0]),
    .ji      (Ji),
    .desvio  (Beqz & Zero),
    .pc_prox (pc_prox)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= BUSCA;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      BUSCA:   estado_d = ESPERA;
      ESPERA:  if (mem_ack) estado_d = ENTREGA;
      ENTREGA: if (instr_ready) estado_d = EscPC ? BUSCA : PARADO;
      PARADO:  estado_d = PARADO;
      default: estado_d = BUSCA;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    mem_req_d = mem_req_q;
    valid_d   = valid_q;
    parado_d  = parado_q;
    case (estado_q)
      BUSCA: mem_req_d = 1'b1;
      ESPERA: begin
        if (mem_ack) begin
          instr_d   = mem_dado;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
        end
      end
      ENTREGA: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (!EscPC) begin
            parado_d = 1'b1;
          end else begin
            pc_d = pc_prox;
          end
        end
      end
      PARADO: begin
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
        parado_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_RESET;
      instr_q   <= '0;
      mem_req_q <= 1'b0;
      valid_q   <= 1'b0;
      parado_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      mem_req_q <= mem_req_d;
      valid_q   <= valid_d;
      parado_q  <= parado_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr_valid = valid_q;
  assign Instrucao   = instr_q;
  assign Opcode      = instr_q[LARG_INSTR-1 -: OPC_LARG];
  assign PC          = pc_q;
  assign parado      = parado_q;

`ifdef BUSCA_CONT_INSTR_EN
  logic [CONT_LARG-1:0] cont_q, cont_d;

  // The halting instruction (EscPC=0) is not counted; saturates at all-ones.
  always_comb begin
    cont_d = cont_q;
    if (estado_q == ENTREGA && instr_ready && EscPC && cont_q != '1) begin
      cont_d = cont_q + CONT_LARG'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign cont_instr = cont_q;
`endif

endmodule
